// File: rtl/smfro_pkg.sv
// Shared types, default parameters and helpers for the SMFRO entropy sequencer.
package smfro_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_PRIME,
    ST_SAMPLE,
    ST_FAIL
  } smfro_state_t;

  localparam int unsigned SMFRO_WIDTH      = 16;
  localparam int unsigned SMFRO_WARMUP_CYC = 256;
  localparam int unsigned SMFRO_SAMPLE_DIV = 8;
  localparam int unsigned SMFRO_RCT_LIMIT  = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned     r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/smfro_sync.sv
// Per-bit 2-flop synchronizer for the free-running oscillator outputs.
module smfro_sync
  import smfro_pkg::*;
#(
  parameter int unsigned WIDTH = SMFRO_WIDTH
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/smfro_ctrl.sv
// SMFRO sequencer: warm-up, periodic sampling, repetition-count health test
// and whitened valid/ready output.
module smfro_ctrl
  import smfro_pkg::*;
#(
  parameter int unsigned WIDTH      = SMFRO_WIDTH,
  parameter int unsigned WARMUP_CYC = SMFRO_WARMUP_CYC,
  parameter int unsigned SAMPLE_DIV = SMFRO_SAMPLE_DIV,
  parameter int unsigned RCT_LIMIT  = SMFRO_RCT_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             fail_clr,
  input  logic [WIDTH-1:0] raw_in,
  output logic             osc_en,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             busy,
  output logic             health_fail
);

  localparam int unsigned WW = (clog2(WARMUP_CYC) < 1) ? 1 : clog2(WARMUP_CYC);
  localparam int unsigned DW = clog2(SAMPLE_DIV);
  localparam int unsigned RW = clog2(RCT_LIMIT + 1);

  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] REP_LIMIT = RW'(RCT_LIMIT);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);

  smfro_state_t     state, state_d;
  logic [WW-1:0]    warm_cnt, warm_d;
  logic [DW-1:0]    div_cnt, div_d;
  logic [RW-1:0]    rep_cnt, rep_d, rep_inc;
  logic [WIDTH-1:0] prev_sample, prev_d;
  logic [WIDTH-1:0] synced;
  logic             load, slot_free, active_d;

  smfro_sync #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .d   (raw_in),
    .q   (synced)
  );

  always_comb begin
    state_d   = state;
    warm_d    = warm_cnt;
    div_d     = div_cnt;
    rep_d     = rep_cnt;
    prev_d    = prev_sample;
    load      = 1'b0;
    slot_free = !rnd_valid || rnd_ready;

    if (synced != prev_sample)  rep_inc = REP_ONE;
    else if (rep_cnt == '1)     rep_inc = rep_cnt;
    else                        rep_inc = rep_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_WARMUP;
          warm_d  = '0;
        end
      end
      ST_WARMUP: begin
        if (warm_cnt == WARM_LAST) begin
          state_d = ST_PRIME;
          warm_d  = '0;
          div_d   = '0;
        end else begin
          warm_d = warm_cnt + 1'b1;
        end
      end
      ST_PRIME: begin
        if (div_cnt == DIV_LAST) begin
          state_d = ST_SAMPLE;
          div_d   = '0;
          prev_d  = synced;
          rep_d   = REP_ONE;
        end else begin
          div_d = div_cnt + 1'b1;
        end
      end
      ST_SAMPLE: begin
        // At terminal count with a full slot the divider simply holds (stall).
        if (div_cnt != DIV_LAST) begin
          div_d = div_cnt + 1'b1;
        end else if (slot_free) begin
          div_d  = '0;
          prev_d = synced;
          rep_d  = rep_inc;
          if (rep_inc == REP_LIMIT) state_d = ST_FAIL;
          else                      load    = 1'b1;
        end
      end
      ST_FAIL: begin
        if (fail_clr) begin
          state_d = ST_IDLE;
          warm_d  = '0;
          div_d   = '0;
          rep_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // stop pre-empts whatever step the active states computed above.
    if (stop && (state inside {ST_WARMUP, ST_PRIME, ST_SAMPLE})) begin
      state_d = ST_IDLE;
      warm_d  = '0;
      div_d   = '0;
      rep_d   = '0;
      prev_d  = prev_sample;
      load    = 1'b0;
    end

    active_d = state_d inside {ST_WARMUP, ST_PRIME, ST_SAMPLE};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      warm_cnt    <= '0;
      div_cnt     <= '0;
      rep_cnt     <= '0;
      prev_sample <= '0;
      osc_en      <= 1'b0;
      busy        <= 1'b0;
      health_fail <= 1'b0;
      rnd_valid   <= 1'b0;
      rnd_data    <= '0;
    end else begin
      state       <= state_d;
      warm_cnt    <= warm_d;
      div_cnt     <= div_d;
      rep_cnt     <= rep_d;
      prev_sample <= prev_d;
      osc_en      <= active_d;
      busy        <= active_d;
      health_fail <= (state_d == ST_FAIL);
      if (state_d == ST_FAIL) begin
        rnd_valid <= 1'b0;
      end else if (load) begin
        rnd_valid <= 1'b1;
        rnd_data  <= synced ^ prev_sample;
      end else if (rnd_ready) begin
        rnd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_smfro_ctrl.sv
// Self-checking bench for smfro_ctrl: vector table for the whitened stream,
// scoreboard on the output handshake, hand sequences for stall/fail/stop/reset.
module tb_smfro_ctrl;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst, start, stop, fail_clr, rnd_ready;
  logic [W-1:0] raw_in;
  logic         osc_en, rnd_valid, busy, health_fail;
  logic [W-1:0] rnd_data;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;
  bit first_chk = 1'b0;

  logic [W-1:0] sb[$];

  typedef struct {
    logic [W-1:0] raw;
    bit           has_out;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  smfro_ctrl #(
    .WIDTH      (16),
    .WARMUP_CYC (4),
    .SAMPLE_DIV (2),
    .RCT_LIMIT  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .fail_clr    (fail_clr),
    .raw_in      (raw_in),
    .osc_en      (osc_en),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .busy        (busy),
    .health_fail (health_fail)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (first_chk && ecnt == 7) check("first_valid_early", 32'(rnd_valid), 32'd0);
    if (first_chk && ecnt == 8) check("first_valid", 32'(rnd_valid), 32'd1);
  endtask

  // Start pulse, then warm-up edges E0..E3; leaves v0 on raw_in for the prime capture.
  task automatic begin_run(input logic [W-1:0] v0);
    start = 1'b1;
    ecnt  = -1;
    tick();
    start = 1'b0;
    check("osc_en_on", 32'(osc_en), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    raw_in = v0;
  endtask

  task automatic feed(input logic [W-1:0] v, input bit push, input logic [W-1:0] exp);
    tick();
    tick();
    raw_in = v;
    if (push) sb.push_back(exp);
  endtask

  // Each accepted word is compared against the oldest expected one.
  always @(negedge clk) begin : mon
    logic [W-1:0] e;
    if (!rst && rnd_valid && rnd_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 32'(rnd_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("word", 32'(rnd_data), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h1234, 1'b0, 16'h0000};
    tbl[1] = '{16'h00FF, 1'b1, 16'h12CB};
    tbl[2] = '{16'hF0F0, 1'b1, 16'hF00F};
    tbl[3] = '{16'hFFFF, 1'b1, 16'h0F0F};
    tbl[4] = '{16'h0000, 1'b1, 16'hFFFF};
    tbl[5] = '{16'h0001, 1'b1, 16'h0001};
    tbl[6] = '{16'h8000, 1'b1, 16'h8001};
    tbl[7] = '{16'h8000, 1'b1, 16'h0000};

    rst = 1'b1; start = 1'b0; stop = 1'b0; fail_clr = 1'b0;
    rnd_ready = 1'b1; raw_in = '0;
    tick(); tick(); tick();
    check("rst_osc_en", 32'(osc_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(rnd_valid), 32'd0);
    check("rst_health", 32'(health_fail), 32'd0);
    check("rst_data", 32'(rnd_data), 32'd0);
    rst = 1'b0;
    tick();

    // Streaming table with consumer always ready
    first_chk = 1'b1;
    begin_run(tbl[0].raw);
    for (int i = 1; i < 8; i++) feed(tbl[i].raw, tbl[i].has_out, tbl[i].exp);
    tick(); tick(); tick();
    first_chk = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stream_stop_busy", 32'(busy), 32'd0);
    check("stream_stop_osc", 32'(osc_en), 32'd0);
    check("stream_stop_valid", 32'(rnd_valid), 32'd0);
    check("stream_drained", 32'(sb.size()), 32'd0);

    // Backpressure: 10 cycles of held word while raw_in churns
    begin_run(16'h1111);
    feed(16'h2222, 1'b1, 16'h3333);
    rnd_ready = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j >= 3) begin
        check("stall_valid", 32'(rnd_valid), 32'd1);
        check("stall_data", 32'(rnd_data), 32'h3333);
      end
      raw_in = W'($urandom);
    end
    raw_in = 16'h4444;
    sb.push_back(16'h6666);
    tick(); tick();
    rnd_ready = 1'b1;
    tick();
    check("release_valid", 32'(rnd_valid), 32'd1);
    check("release_data", 32'(rnd_data), 32'h6666);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("bp_stop_valid", 32'(rnd_valid), 32'd0);
    check("bp_stop_busy", 32'(busy), 32'd0);

    // Repetition-count failure on a constant raw word
    begin_run(16'hAAAA);
    feed(16'hAAAA, 1'b1, 16'h0000);
    feed(16'hAAAA, 1'b0, 16'h0000);
    tick(); tick();
    check("pre_fail_health", 32'(health_fail), 32'd0);
    check("pre_fail_busy", 32'(busy), 32'd1);
    tick();
    check("fail_health", 32'(health_fail), 32'd1);
    check("fail_osc", 32'(osc_en), 32'd0);
    check("fail_valid", 32'(rnd_valid), 32'd0);
    check("fail_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fail_start_ignored", 32'(health_fail), 32'd1);
    check("fail_start_busy", 32'(busy), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("fail_stop_ignored", 32'(health_fail), 32'd1);
    fail_clr = 1'b1;
    tick();
    fail_clr = 1'b0;
    check("fail_clr_health", 32'(health_fail), 32'd0);
    check("fail_clr_busy", 32'(busy), 32'd0);

    // start+stop together in IDLE, then stop mid-warm-up
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_osc", 32'(osc_en), 32'd0);
    tick();
    check("ss_still_idle", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("warm_busy", 32'(busy), 32'd1);
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("warm_stop_busy", 32'(busy), 32'd0);
    check("warm_stop_osc", 32'(osc_en), 32'd0);

    // Fresh full warm-up, word left pending, then reset
    first_chk = 1'b1;
    begin_run(16'h3C3C);
    feed(16'hC3C3, 1'b1, 16'hFFFF);
    rnd_ready = 1'b0;
    tick(); tick(); tick();
    first_chk = 1'b0;
    check("pend_data", 32'(rnd_data), 32'hFFFF);
    tick();
    check("pend_valid", 32'(rnd_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(rnd_valid), 32'd0);
    check("mid_rst_data", 32'(rnd_data), 32'd0);
    check("mid_rst_osc", 32'(osc_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_health", 32'(health_fail), 32'd0);
    sb.delete();
    rst = 1'b0;
    rnd_ready = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(rnd_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
